single_cycle_cpu: RTL and testbench

// - Single-cycle RV32I-subset core: fetch, decode, execute, memory and writeback all complete in one clk.
// - Top-level processor block: contains its own instruction memory, register file and data memory.
// - Benches preload these memories hierarchically; halt tells the bench when the program has finished.

---
 rtl/single_cycle_cpu.sv | 203 ++++++++++++++++++++
 tb/tb_single_cycle_cpu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : single_cycle_cpu
// Brief    : Single-cycle RV32I-subset core with internal IMEM, register file
//            and DMEM. Macro SCPU_BRANCH_EXT_EN adds blt/bge/bltu/bgeu.
// Revision : 1.0 - initial release
// ============================================================================
module single_cycle_cpu #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  output logic halt
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  logic [31:0] PC, instruction, next_pc, pc_plus4;
  logic [4:0]  Rs1, Rs2, Rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic        jal, jalr, valid, take, branch_f3_ok;
  logic [1:0]  a_sel;
  logic [2:0]  alu_f3;
  logic        alu_alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm;
  logic [31:0] rs1_data, rs2_data, alu_a, alu_b, alu_result, sra_res;
  logic [31:0] mem_rdata, wb_data;
  logic        unused_ctrl;

  // Named scopes give the memories the hierarchical paths benches preload.
  if (1'b1) begin : InstMem
    logic [31:0] IMem [0:IMEM_WORDS-1];
    assign instruction = IMem[PC[IW+1:2]];
  end

  assign opcode = instruction[6:0];
  assign Rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign Rs1    = instruction[19:15];
  assign Rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
  assign imm_u = {instruction[31:12], 12'h000};

`ifdef SCPU_BRANCH_EXT_EN
  assign branch_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
`else
  assign branch_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
`endif

  // Every control signal stays 0 unless the encoding is recognised.
  always_comb begin
    valid    = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    jal      = 1'b0;
    jalr     = 1'b0;
    a_sel    = A_RS1;
    alu_f3   = 3'b000;
    alu_alt  = 1'b0;
    imm      = imm_i;
    case (opcode)
      OP_R: if (funct7 == 7'b0000000 || (funct7 == 7'b0100000 &&
                (funct3 == 3'b000 || funct3 == 3'b101))) begin
        valid = 1'b1; RegWrite = 1'b1; alu_f3 = funct3; alu_alt = funct7[5];
      end
      OP_IMM: if ((funct3 != 3'b001 && funct3 != 3'b101) || funct7 == 7'b0000000 ||
                  (funct3 == 3'b101 && funct7 == 7'b0100000)) begin
        valid = 1'b1; ALUSrc = 1'b1; RegWrite = 1'b1; alu_f3 = funct3;
        alu_alt = (funct3 == 3'b101) && funct7[5];
      end
      OP_LOAD: if (funct3 == 3'b010) begin
        valid = 1'b1; ALUSrc = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        valid = 1'b1; ALUSrc = 1'b1; MemWrite = 1'b1; imm = imm_s;
      end
      OP_BRANCH: if (branch_f3_ok) begin
        valid = 1'b1; Branch = 1'b1;
      end
      OP_JAL: begin
        valid = 1'b1; RegWrite = 1'b1; jal = 1'b1;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        valid = 1'b1; ALUSrc = 1'b1; RegWrite = 1'b1; jalr = 1'b1;
      end
      OP_LUI: begin
        valid = 1'b1; ALUSrc = 1'b1; RegWrite = 1'b1; a_sel = A_ZERO; imm = imm_u;
      end
      OP_AUIPC: begin
        valid = 1'b1; ALUSrc = 1'b1; RegWrite = 1'b1; a_sel = A_PC; imm = imm_u;
      end
      default: valid = 1'b0;
    endcase
  end

  assign halt        = ~valid;
  assign unused_ctrl = MemRead;

  if (1'b1) begin : Registers
    logic [31:0] Registers [0:31];
    always_ff @(posedge clk) begin
      if (RegWrite && !reset && Rd != 5'd0) Registers[Rd] <= wb_data;
    end
    assign rs1_data = (Rs1 == 5'd0) ? 32'h0 : Registers[Rs1];
    assign rs2_data = (Rs2 == 5'd0) ? 32'h0 : Registers[Rs2];
  end

  always_comb begin
    alu_a = rs1_data;
    case (a_sel)
      A_PC:    alu_a = PC;
      A_ZERO:  alu_a = 32'h0;
      default: alu_a = rs1_data;
    endcase
  end

  assign alu_b = ALUSrc ? imm : rs2_data;
  // Kept in its own assignment so the shift stays arithmetic.
  assign sra_res = $signed(alu_a) >>> alu_b[4:0];

  always_comb begin
    alu_result = 32'h0;
    case (alu_f3)
      3'b000:  alu_result = alu_alt ? (alu_a - alu_b) : (alu_a + alu_b);
      3'b001:  alu_result = alu_a << alu_b[4:0];
      3'b010:  alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      3'b011:  alu_result = {31'h0, alu_a < alu_b};
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = alu_alt ? sra_res : (alu_a >> alu_b[4:0]);
      3'b110:  alu_result = alu_a | alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  if (1'b1) begin : Mem
    logic [31:0] Mem [0:DMEM_WORDS-1];
    always_ff @(posedge clk) begin
      if (MemWrite && !reset) Mem[alu_result[DW+1:2]] <= rs2_data;
    end
    assign mem_rdata = Mem[alu_result[DW+1:2]];
  end

  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000:  take = (rs1_data == rs2_data);
      3'b001:  take = (rs1_data != rs2_data);
`ifdef SCPU_BRANCH_EXT_EN
      3'b100:  take = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  take = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  take = (rs1_data <  rs2_data);
      3'b111:  take = (rs1_data >= rs2_data);
`endif
      default: take = 1'b0;
    endcase
  end

  assign pc_plus4 = PC + 32'd4;
  assign wb_data  = MemtoReg ? mem_rdata : ((jal || jalr) ? pc_plus4 : alu_result);

  always_comb begin
    next_pc = pc_plus4;
    if (jal)                 next_pc = PC + imm_j;
    else if (jalr)           next_pc = {alu_result[31:1], 1'b0};
    else if (Branch && take) next_pc = PC + imm_b;
  end

  always_ff @(posedge clk) begin
    if (reset)      PC <= RESET_PC;
    else if (!halt) PC <= next_pc;
  end

endmodule
`default_nettype wire

// File: tb/tb_single_cycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_single_cycle_cpu
// Brief    : Directed programs for single_cycle_cpu with a queued scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_single_cycle_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt;

  single_cycle_cpu dut (.clk(clk), .reset(reset), .halt(halt));

  always #5 clk = ~clk;

  localparam int PH_ASSERT = 0, PH_RELEASE = 1, PH_HALT = 2;
  localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_HALT = 3, K_WECNT = 4, K_WEPC = 5;

  typedef struct {
    int          phase;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(int ph, int k, int idx, logic [31:0] e, string n);
    item_t it;
    it.phase = ph; it.kind = k; it.idx = idx; it.exp = e; it.name = n;
    sb.push_back(it);
  endfunction

  // Instruction encoders
  function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                        logic [31:0] f3, logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                        logic [31:0] rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                        logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_u(logic [31:0] imm, logic [31:0] rd, logic [6:0] op);
    return {imm[31:12], rd[4:0], op};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011;

  // Monitor: drains queued expectations when reset asserts, releases, or halt rises
  logic        prev_reset = 1'b1;
  logic        halted = 1'b0;
  int          we_cnt = 0;
  logic [31:0] we_pc = 32'h0;

  initial begin
    item_t       it;
    logic [31:0] act;
    logic        ev_assert, ev_release, ev_halt;
    forever begin
      @(negedge clk);
      ev_assert  = reset && !prev_reset;
      ev_release = !reset && prev_reset;
      if (ev_release) begin
        halted = 1'b0;
        we_cnt = 0;
      end
      if (!reset && dut.MemWrite) begin
        we_cnt++;
        we_pc = dut.PC;
      end
      ev_halt = !reset && halt && !halted;
      if (ev_halt) halted = 1'b1;
      while (sb.size() > 0 && ((sb[0].phase == PH_ASSERT && ev_assert) ||
                               (sb[0].phase == PH_RELEASE && ev_release) ||
                               (sb[0].phase == PH_HALT && ev_halt))) begin
        it = sb.pop_front();
        case (it.kind)
          K_REG:   act = dut.Registers.Registers[it.idx];
          K_MEM:   act = dut.Mem.Mem[it.idx];
          K_PC:    act = dut.PC;
          K_HALT:  act = {31'h0, halt};
          K_WECNT: act = we_cnt;
          default: act = we_pc;
        endcase
        check(it.name, act, it.exp);
      end
      prev_reset = reset;
    end
  end

  task automatic begin_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_prog(input logic [31:0] words[$]);
    for (int i = 0; i < 64; i++) dut.InstMem.IMem[i] = 32'h0;
    for (int i = 0; i < words.size(); i++) dut.InstMem.IMem[i] = words[i];
  endtask

  task automatic preset_regs();
    dut.Registers.Registers[0] = 32'h0;
    for (int i = 1; i < 32; i++) dut.Registers.Registers[i] = 32'h1000_0000 + i;
  endtask

  task automatic run_to_halt(string tag);
    int n;
    n = 0;
    @(posedge clk); #1 reset = 1'b0;
    while (halt !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (halt !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: halt=%b after %0d cycles, required 1", tag, halt, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] p[$];

    // Program 1: addi chain, halt on zero word, PC hold
    @(posedge clk); #1;
    preset_regs();
    p = '{enc_i(5, 0, 0, 1, OPI), enc_i(-7, 1, 0, 2, OPI), 32'h0};
    load_prog(p);
    push_exp(PH_RELEASE, K_PC,    0, 32'h0,         "reset_pc");
    push_exp(PH_RELEASE, K_HALT,  0, 32'h0,         "reset_halt");
    push_exp(PH_HALT,    K_PC,    0, 32'h8,         "p1_halt_pc");
    push_exp(PH_HALT,    K_REG,   1, 32'h5,         "addi_x1");
    push_exp(PH_HALT,    K_REG,   2, 32'hFFFF_FFFE, "addi_neg_x2");
    push_exp(PH_HALT,    K_WECNT, 0, 32'h0,         "p1_no_memwrite");
    push_exp(PH_ASSERT,  K_PC,    0, 32'h8,         "p1_pc_hold");
    push_exp(PH_ASSERT,  K_HALT,  0, 32'h1,         "p1_halt_hold");
    run_to_halt("p1");

    // Program 2: R-type and I-type ALU, lui, auipc
    begin_reset();
    preset_regs();
    dut.Registers.Registers[3] = 32'h8000_0000;
    dut.Registers.Registers[4] = 32'h1;
    p = '{enc_r(0, 3, 3, 0, 5), enc_r(0, 4, 3, 2, 6), enc_r(0, 4, 3, 3, 7),
          enc_r(32'h20, 4, 3, 5, 8), enc_r(32'h20, 3, 4, 0, 15), enc_r(0, 4, 3, 5, 16),
          enc_r(0, 4, 4, 1, 17), enc_i(32'h404, 3, 5, 18, OPI), enc_i(-1, 4, 3, 19, OPI),
          enc_u(32'h1234_5000, 20, 7'b0110111), enc_u(32'h0000_1000, 21, 7'b0010111), 32'h0};
    load_prog(p);
    push_exp(PH_HALT, K_PC,   0, 32'h2C,        "p2_halt_pc");
    push_exp(PH_HALT, K_REG,  5, 32'h0,         "add_wrap");
    push_exp(PH_HALT, K_REG,  6, 32'h1,         "slt_signed");
    push_exp(PH_HALT, K_REG,  7, 32'h0,         "sltu_unsigned");
    push_exp(PH_HALT, K_REG,  8, 32'hC000_0000, "sra");
    push_exp(PH_HALT, K_REG, 15, 32'h8000_0001, "sub");
    push_exp(PH_HALT, K_REG, 16, 32'h4000_0000, "srl");
    push_exp(PH_HALT, K_REG, 17, 32'h2,         "sll");
    push_exp(PH_HALT, K_REG, 18, 32'hF800_0000, "srai");
    push_exp(PH_HALT, K_REG, 19, 32'h1,         "sltiu");
    push_exp(PH_HALT, K_REG, 20, 32'h1234_5000, "lui");
    push_exp(PH_HALT, K_REG, 21, 32'h0000_1028, "auipc");
    run_to_halt("p2");

    // Program 3: sw/lw, then reset while halted with state preserved
    begin_reset();
    preset_regs();
    dut.Registers.Registers[1] = 32'h8;
    dut.Registers.Registers[2] = 32'hDEAD_BEEF;
    dut.Mem.Mem[3] = 32'h0;
    p = '{enc_s(4, 2, 1), enc_i(12, 0, 2, 9, 7'b0000011), 32'h0};
    load_prog(p);
    push_exp(PH_HALT,   K_PC,    0, 32'h8,         "p3_halt_pc");
    push_exp(PH_HALT,   K_MEM,   3, 32'hDEAD_BEEF, "sw_mem3");
    push_exp(PH_HALT,   K_REG,   9, 32'hDEAD_BEEF, "lw_x9");
    push_exp(PH_HALT,   K_WECNT, 0, 32'h1,         "memwrite_cycles");
    push_exp(PH_HALT,   K_WEPC,  0, 32'h0,         "memwrite_pc");
    push_exp(PH_ASSERT, K_HALT,  0, 32'h1,         "p3_halt_before_reset");
    push_exp(PH_ASSERT, K_PC,    0, 32'h8,         "p3_pc_before_reset");
    run_to_halt("p3");

    begin_reset();
    dut.Registers.Registers[2] = 32'h1234_5678;
    push_exp(PH_RELEASE, K_PC,    0, 32'h0,         "midreset_pc");
    push_exp(PH_RELEASE, K_MEM,   3, 32'hDEAD_BEEF, "midreset_mem_kept");
    push_exp(PH_RELEASE, K_REG,   9, 32'hDEAD_BEEF, "midreset_reg_kept");
    push_exp(PH_HALT,    K_MEM,   3, 32'h1234_5678, "rerun_sw_mem3");
    push_exp(PH_HALT,    K_REG,   9, 32'h1234_5678, "rerun_lw_x9");
    push_exp(PH_HALT,    K_WECNT, 0, 32'h1,         "rerun_memwrite_cycles");
    run_to_halt("p3b");

    // Program 4: write to x0, jal, jalr
    begin_reset();
    preset_regs();
    p = '{enc_i(9, 0, 0, 0, OPI), 32'h0000_0013, 32'h0000_0013, 32'h0000_0013,
          enc_j(12, 1), enc_i(7, 0, 0, 13, OPI), 32'h0, enc_i(0, 1, 0, 0, 7'b1100111)};
    load_prog(p);
    push_exp(PH_HALT, K_PC,   0, 32'h18, "p4_halt_pc");
    push_exp(PH_HALT, K_REG,  0, 32'h0,  "x0_zero");
    push_exp(PH_HALT, K_REG,  1, 32'h14, "jal_link");
    push_exp(PH_HALT, K_REG, 13, 32'h7,  "jalr_target_exec");
    run_to_halt("p4");

    // Program 5: beq taken, bne not taken
    begin_reset();
    preset_regs();
    p = '{enc_b(8, 0, 0, 0), enc_i(1, 0, 0, 10, OPI), enc_b(8, 0, 0, 1),
          enc_i(2, 0, 0, 11, OPI), 32'h0};
    load_prog(p);
    push_exp(PH_HALT, K_PC,   0, 32'h10,        "p5_halt_pc");
    push_exp(PH_HALT, K_REG, 10, 32'h1000_000A, "beq_skipped");
    push_exp(PH_HALT, K_REG, 11, 32'h2,         "bne_fallthrough");
    run_to_halt("p5");

    // Program 6: blt with negative rs1
    begin_reset();
    preset_regs();
    dut.Registers.Registers[3] = 32'h8000_0000;
    dut.Registers.Registers[4] = 32'h1;
    p = '{enc_b(8, 4, 3, 4), enc_i(1, 0, 0, 22, OPI), enc_i(2, 0, 0, 23, OPI), 32'h0};
    load_prog(p);
`ifdef SCPU_BRANCH_EXT_EN
    push_exp(PH_HALT, K_PC,   0, 32'hC,         "blt_halt_pc");
    push_exp(PH_HALT, K_REG, 22, 32'h1000_0016, "blt_skipped");
    push_exp(PH_HALT, K_REG, 23, 32'h2,         "blt_target_exec");
`else
    push_exp(PH_HALT, K_PC,   0, 32'h0,         "blt_halt_pc");
    push_exp(PH_HALT, K_REG, 22, 32'h1000_0016, "blt_no_write");
    push_exp(PH_HALT, K_REG, 23, 32'h1000_0017, "blt_no_write2");
`endif
    run_to_halt("p6");

    check("scoreboard_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
